axi4_stream_realigner: RTL



---
 rtl/axi4_stream_realigner.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi4_stream_realigner.sv
// Per-packet AXI4-Stream byte realigner: PAD inserts N null lanes ahead of byte 0, STRIP drops the first N bytes.
// Latency: 1 cycle from input handshake to output valid once a full beat (or the packet tail) is buffered.
// Backpressure: pkt_i_tready drops when the two-beat buffer lacks room, or while the previous packet's tail drains.
module axi4_stream_realigner #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_B_W-1:0] shift_i,
  input  logic                      strip_i,
  input  logic                      pkt_i_tvalid,
  output logic                      pkt_i_tready,
  input  logic [DATA_WIDTH-1:0]     pkt_i_tdata,
  input  logic [DATA_WIDTH_B-1:0]   pkt_i_tkeep,
  input  logic [DATA_WIDTH_B-1:0]   pkt_i_tstrb,
  input  logic                      pkt_i_tlast,
  input  logic [ID_WIDTH-1:0]       pkt_i_tid,
  input  logic [DEST_WIDTH-1:0]     pkt_i_tdest,
  input  logic [USER_WIDTH-1:0]     pkt_i_tuser,
  output logic                      pkt_o_tvalid,
  input  logic                      pkt_o_tready,
  output logic [DATA_WIDTH-1:0]     pkt_o_tdata,
  output logic [DATA_WIDTH_B-1:0]   pkt_o_tkeep,
  output logic [DATA_WIDTH_B-1:0]   pkt_o_tstrb,
  output logic                      pkt_o_tlast,
  output logic [ID_WIDTH-1:0]       pkt_o_tid,
  output logic [DEST_WIDTH-1:0]     pkt_o_tdest,
  output logic [USER_WIDTH-1:0]     pkt_o_tuser
);

  localparam int B  = DATA_WIDTH_B;
  localparam int CW = DATA_WIDTH_B_W + 2;
  localparam logic [CW-1:0] BEAT = CW'(B);
  localparam logic [CW-1:0] CAP  = CW'(2 * B);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]              state, state_n;
  logic                    tail_seen, tail_n;
  logic [CW-1:0]           cnt, cnt_n, tx, kept, rx, add, sh;
  logic [2*DATA_WIDTH-1:0] buf_dat, buf_dat_n, inc_dat;
  logic [2*B-1:0]          buf_keep, buf_keep_n, inc_keep;
  logic [B-1:0]            lane_en;
  logic [DATA_WIDTH-1:0]   in_dat_m;
  logic                    out_vld, out_last, out_fire, in_rdy, in_fire, first;
  logic [ID_WIDTH-1:0]     id_q;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [USER_WIDTH-1:0]   user_q;

  // The buffer is packed from lane 0 and every byte above cnt is kept zero,
  // so the output beat is simply the low lanes and appends can be OR-ed in.
  assign out_vld  = (cnt >= BEAT) || (tail_seen && (cnt != '0));
  assign out_last = tail_seen && (cnt != '0) && (cnt <= BEAT);
  assign out_fire = out_vld && pkt_o_tready;
  assign tx       = out_fire ? ((cnt >= BEAT) ? BEAT : cnt) : '0;
  assign kept     = cnt - tx;
  // Once the tail is in, the next packet may only enter as the last beat leaves,
  // so two packets never share the buffer.
  assign in_rdy   = (state != TAIL) &&
                    (tail_seen ? (out_fire && out_last) : ((kept + BEAT) <= CAP));
  assign in_fire  = pkt_i_tvalid && in_rdy;
  assign first    = (state == IDLE) || tail_seen;
  assign sh       = CW'(shift_i);

  // Align the incoming beat; the whole offset is applied on the first beat,
  // so shift_i/strip_i are only ever looked at when a packet starts.
  always_comb begin
    lane_en  = pkt_i_tlast ? (pkt_i_tkeep & pkt_i_tstrb) : '1;
    in_dat_m = '0;
    rx       = '0;
    for (int i = 0; i < B; i++) begin
      in_dat_m[8*i +: 8] = lane_en[i] ? pkt_i_tdata[8*i +: 8] : 8'h00;
      rx = rx + CW'(lane_en[i]);
    end
    inc_dat  = {{DATA_WIDTH{1'b0}}, in_dat_m};
    inc_keep = {{B{1'b0}}, lane_en};
    add      = rx;
    if (first) begin
      if (strip_i) begin
        inc_dat  = inc_dat >> {shift_i, 3'b000};
        inc_keep = inc_keep >> shift_i;
        add      = (rx > sh) ? (rx - sh) : '0;
      end else begin
        inc_dat  = inc_dat << {shift_i, 3'b000};
        inc_keep = inc_keep << shift_i;
        add      = rx + sh;
      end
    end
  end

  // Drop the transmitted bytes from the front and append the new ones behind what is left.
  always_comb begin
    buf_dat_n  = buf_dat >> {tx, 3'b000};
    buf_keep_n = buf_keep >> tx;
    cnt_n      = kept;
    if (in_fire) begin
      buf_dat_n  = buf_dat_n | (inc_dat << {kept, 3'b000});
      buf_keep_n = buf_keep_n | (inc_keep << kept);
      cnt_n      = kept + add;
    end
  end

  // Packet-level state: TAIL while more than one beat remains after the input tlast.
  always_comb begin
    state_n = state;
    tail_n  = tail_seen;
    if (in_fire) begin
      if (pkt_i_tlast) begin
        tail_n = 1'b1;
        if (cnt_n > BEAT) begin
          state_n = TAIL;
        end else if (cnt_n == '0) begin
          state_n = IDLE;
          tail_n  = 1'b0;
        end else begin
          state_n = RUN;
        end
      end else begin
        state_n = RUN;
        tail_n  = 1'b0;
      end
    end else if (out_fire && out_last) begin
      state_n = IDLE;
      tail_n  = 1'b0;
    end else if ((state == TAIL) && (cnt_n <= BEAT)) begin
      state_n = RUN;
    end
  end

  // State, buffer and first-beat sideband registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tail_seen <= 1'b0;
      cnt       <= '0;
      buf_dat   <= '0;
      buf_keep  <= '0;
      id_q      <= '0;
      dest_q    <= '0;
      user_q    <= '0;
    end else begin
      state     <= state_n;
      tail_seen <= tail_n;
      cnt       <= cnt_n;
      buf_dat   <= buf_dat_n;
      buf_keep  <= buf_keep_n;
      if (in_fire && first) begin
        id_q   <= pkt_i_tid;
        dest_q <= pkt_i_tdest;
        user_q <= pkt_i_tuser;
      end
    end
  end

  assign pkt_i_tready = in_rdy;
  assign pkt_o_tvalid = out_vld;
  assign pkt_o_tlast  = out_last;
  assign pkt_o_tdata  = buf_dat[DATA_WIDTH-1:0];
  assign pkt_o_tkeep  = buf_keep[B-1:0];
  assign pkt_o_tstrb  = buf_keep[B-1:0];
  assign pkt_o_tid    = id_q;
  assign pkt_o_tdest  = dest_q;
  assign pkt_o_tuser  = user_q;

endmodule
